// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types, BCD constants and the slice adder function for addsub_seq
package addsub_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] BCD_ADJ = 4'h6;
  localparam logic [3:0] BCD_MAX = 4'h9;

  // Widest slice slice_add can handle; callers zero-pad and pass the active nibble count.
  localparam int SLICE_MAX = 64;

  typedef struct packed {
    logic                 cout;
    logic [SLICE_MAX-1:0] sum;
    logic                 nib0_cout;
  } slice_res_t;

  function automatic logic [4:0] nib_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic dec);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (dec && (s > {1'b0, BCD_MAX})) nib_add = {1'b1, s[3:0] + BCD_ADJ};
    else                              nib_add = s;
  endfunction

  function automatic slice_res_t slice_add(input logic [SLICE_MAX-1:0] a,
                                           input logic [SLICE_MAX-1:0] b,
                                           input logic cin, input logic dec,
                                           input int nnib);
    slice_res_t r;
    logic       c;
    logic [4:0] n;
    r = '0;
    c = cin;
    for (int i = 0; i < SLICE_MAX / 4; i++) begin
      if (i < nnib) begin
        n = nib_add(a[4*i +: 4], b[4*i +: 4], c, dec);
        r.sum[4*i +: 4] = n[3:0];
        c = n[4];
        if (i == 0) r.nib0_cout = c;
      end
    end
    r.cout = c;
    return r;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SLICE-bit adder, nibble carry chain, optional BCD correction
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic             dec,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             nib0_cout
);
  import addsub_pkg::*;

  slice_res_t r;

  assign r         = slice_add(SLICE_MAX'(a), SLICE_MAX'(b), cin, dec, SLICE / 4);
  assign sum       = r.sum[SLICE-1:0];
  assign cout      = r.cout;
  assign nib0_cout = r.nib0_cout;

  generate
    if (SLICE < SLICE_MAX) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^r.sum[SLICE_MAX-1:SLICE];
    end
  endgenerate

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - slice-serial add/subtract engine; ADDSUB_SEQ_BCD_EN enables packed-BCD mode
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK_n,
  input  logic             RESET_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Carry_In,
  input  logic             Dec,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Res,
  output logic             Carry,
  output logic             Half_Carry,
  output logic             Zero,
  output logic             Overflow
);
  import addsub_pkg::*;

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_q, hc_q, dec_q, a_msb, b_msb;

  logic [WIDTH-1:0] b_in, next_res;
  logic             dec_in, last, hc_fin, ovf_fin;
  logic [SLICE-1:0] s_sum;
  logic             s_cout, s_nib0;

  always_comb begin
    b_in = Sub ? ~B : B;
`ifdef ADDSUB_SEQ_BCD_EN
    dec_in = Dec;
    // Decimal subtract uses the per-nibble 9's complement instead of bit inversion.
    if (Dec && Sub) begin
      for (int i = 0; i < WIDTH / 4; i++) b_in[4*i +: 4] = BCD_MAX - B[4*i +: 4];
    end
`else
    dec_in = 1'b0;
`endif
  end

`ifndef ADDSUB_SEQ_BCD_EN
  logic unused_dec;
  assign unused_dec = Dec;
`endif

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a         (a_sr[SLICE-1:0]),
    .b         (b_sr[SLICE-1:0]),
    .cin       (carry_q),
    .dec       (dec_q),
    .sum       (s_sum),
    .cout      (s_cout),
    .nib0_cout (s_nib0)
  );

  always_comb begin
    next_res = (res_sr >> SLICE) | (WIDTH'(s_sum) << (WIDTH - SLICE));
    last     = (cnt == CW'(NSLICE - 1));
    hc_fin   = (cnt == '0) ? s_nib0 : hc_q;
    ovf_fin  = (a_msb == b_msb) && (next_res[WIDTH-1] != a_msb) && !dec_q;
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      carry_q    <= 1'b0;
      hc_q       <= 1'b0;
      dec_q      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Res        <= '0;
      Carry      <= 1'b0;
      Half_Carry <= 1'b0;
      Zero       <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_sr    <= A;
            b_sr    <= b_in;
            carry_q <= Carry_In;
            dec_q   <= dec_in;
            a_msb   <= A[WIDTH-1];
            b_msb   <= b_in[WIDTH-1];
            res_sr  <= '0;
            cnt     <= '0;
            Busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_sr  <= next_res;
          a_sr    <= a_sr >> SLICE;
          b_sr    <= b_sr >> SLICE;
          carry_q <= s_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == '0) hc_q <= s_nib0;
          if (last) begin
            Res        <= next_res;
            Carry      <= s_cout;
            Half_Carry <= hc_fin;
            Zero       <= ~|next_res;
            Overflow   <= ovf_fin;
            Done       <= 1'b1;
            Busy       <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - scoreboard bench for addsub_seq with directed hand-computed vectors
module tb_addsub_seq;
  localparam int W  = 16;
  localparam int NS = 4;

  logic          CLK_n = 1'b0;
  logic          RESET_n = 1'b0;
  logic          Start = 1'b0;
  logic [W-1:0]  A = '0, B = '0;
  logic          Sub = 1'b0, Carry_In = 1'b0, Dec = 1'b0;
  logic          Busy, Done, Carry, Half_Carry, Zero, Overflow;
  logic [W-1:0]  Res;

  addsub_seq #(.WIDTH(W), .SLICE(4)) dut (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .Start(Start), .A(A), .B(B), .Sub(Sub),
    .Carry_In(Carry_In), .Dec(Dec), .Busy(Busy), .Done(Done), .Res(Res), .Carry(Carry),
    .Half_Carry(Half_Carry), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 CLK_n = ~CLK_n;

  typedef struct {
    logic [W-1:0] res;
    logic         c, h, z, v;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK_n) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expected result.
  always @(negedge CLK_n) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_without_request", {31'd0, Done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"},     {16'd0, Res},        {16'd0, e.res});
        chk({e.name, "_carry"},   {31'd0, Carry},      {31'd0, e.c});
        chk({e.name, "_hcarry"},  {31'd0, Half_Carry}, {31'd0, e.h});
        chk({e.name, "_zero"},    {31'd0, Zero},       {31'd0, e.z});
        chk({e.name, "_ovf"},     {31'd0, Overflow},   {31'd0, e.v});
        chk({e.name, "_latency"}, cyc,                 e.cyc);
        chk({e.name, "_busy_in_done"}, {31'd0, Busy},  32'd0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input logic dec, input logic [W-1:0] er,
                       input logic ec, input logic eh, input logic ez, input logic ev,
                       input string nm, input bit push = 1'b1);
    exp_t e;
    @(negedge CLK_n);
    A = a; B = b; Sub = sub; Carry_In = cin; Dec = dec; Start = 1'b1;
    if (push) begin
      e.res = er; e.c = ec; e.h = eh; e.z = ez; e.v = ev;
      e.cyc = cyc + 1 + NS; e.name = nm;
      sb.push_back(e);
    end
    @(negedge CLK_n);
    Start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || Busy) && t < 100) begin
      @(negedge CLK_n);
      #1;
      t++;
    end
    chk({nm, "_drain"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK_n);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_res",  {16'd0, Res},  32'd0);
    chk("rst_carry", {31'd0, Carry}, 32'd0);
    chk("rst_hcarry", {31'd0, Half_Carry}, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd0);
    chk("rst_ovf",  {31'd0, Overflow}, 32'd0);
    RESET_n = 1'b1;

    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b1, 1'b0, 1'b0, "add_basic");
    for (int i = 0; i < NS; i++) begin
      chk("busy_run", {31'd0, Busy}, 32'd1);
      @(negedge CLK_n);
    end
    chk("busy_after_run", {31'd0, Busy}, 32'd0);
    drain("add_basic");

    issue(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, "sub_borrow");
    drain("sub_borrow");
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, "add_wrap_zero");
    drain("add_wrap_zero");
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
    drain("add_ovf");
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, "sub_ovf");
    drain("sub_ovf");

    // Start during RUN is ignored; Start in the Done cycle is accepted.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, "busy_ignore");
    @(negedge CLK_n);
    A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b0; Carry_In = 1'b1; Start = 1'b1;
    @(negedge CLK_n);
    Start = 1'b0;
    @(negedge CLK_n);
    issue(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_sub");
    drain("b2b");

    // Asynchronous reset mid-operation: outputs clear at once, no Done later.
    issue(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "aborted", 1'b0);
    @(negedge CLK_n);
    RESET_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    chk("arst_res",  {16'd0, Res},  32'd0);
    chk("arst_carry", {31'd0, Carry}, 32'd0);
    chk("arst_hcarry", {31'd0, Half_Carry}, 32'd0);
    @(negedge CLK_n);
    RESET_n = 1'b1;
    repeat (10) @(negedge CLK_n);
    chk("arst_idle_busy", {31'd0, Busy}, 32'd0);

`ifdef ADDSUB_SEQ_BCD_EN
    issue(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, "bcd_add");
    drain("bcd_add");
    issue(16'h0100, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b0, "bcd_sub");
    drain("bcd_sub");
`else
    issue(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h099A, 1'b0, 1'b0, 1'b0, 1'b0, "dec_ignored_add");
    drain("dec_ignored_add");
    issue(16'h0100, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, "dec_ignored_sub");
    drain("dec_ignored_sub");
`endif

    repeat (3) @(negedge CLK_n);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Multi-cycle, slice-serial add/subtract engine for wide operands in the T80 datapath.
- Processes WIDTH-bit operands SLICE bits per clock, LSB slice first, with a start/done handshake.
- Produces Res, Carry, Half_Carry, Zero and Overflow.
- Arithmetic convention: Res = A + (Sub ? ~B : B) + Carry_In. For a subtract, Carry_In=1 means no borrow-in and Carry=1 means no borrow-out.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; must be a multiple of 4; NSLICE = WIDTH/SLICE.

Ports:
- CLK_n  in  1  clock, rising edge.
- RESET_n  in  1  reset, asynchronous, active-low.
- Start  in  1  request; sampled only when Busy=0.
- A  in  WIDTH  operand A; captured on an accepted Start.
- B  in  WIDTH  operand B; captured on an accepted Start.
- Sub  in  1  1 = subtract (B inverted); captured on an accepted Start.
- Carry_In  in  1  carry into bit 0; captured on an accepted Start.
- Dec  in  1  decimal (packed BCD) mode; captured on an accepted Start; ignored unless ADDSUB_SEQ_BCD_EN is defined.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; results valid and updated.
- Res  out  WIDTH  result.
- Carry  out  1  carry out of bit WIDTH-1.
- Half_Carry  out  1  carry out of bit 3.
- Zero  out  1  Res == 0.
- Overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (RESET_n low, asynchronous, any state):
  - state=IDLE; Busy=0, Done=0, Res=0, Carry=0, Half_Carry=0, Zero=0, Overflow=0.
  - Internal operand, shift and counter registers cleared.
  - Reset mid-operation abandons the operation; no Done is produced.
- FSM, two states:
  - IDLE: Busy=0. Start=1 at a rising edge → capture A, B_i=(Sub?~B:B), Carry_In, Dec; slice counter=0; go RUN.
  - RUN: Busy=1. Each edge processes slice[cnt] = A_slice + B_i_slice + c, where c is Carry_In for slice 0 and the stored inter-slice carry otherwise. The sum goes into the internal result shift register; the carry is stored; cnt increments.
  - At the edge processing slice NSLICE-1: output registers load, Done=1 for exactly the following cycle, state→IDLE.
- Latency:
  - Start accepted at edge k → Done high, outputs valid, in the cycle after edge k+NSLICE; Busy high for NSLICE cycles.
  - NSLICE=1 is legal: Done follows the edge after Start.
- Start while Busy=1 is ignored; no queueing; captured operands are not disturbed.
- Back-to-back: Busy=0 during the Done cycle, so Start may be accepted then. Outputs keep the completed result until the next completion.
- Output registers change only on completion edges and on reset.
- Flags:
  - Half_Carry = carry out of bit 3, i.e. out of nibble 0 of slice 0; latched internally at slice 0.
  - Overflow = (A[W-1]==B_i[W-1]) && (Res[W-1]!=A[W-1]).
  - Zero = ~|Res.
  - All flags are computed from the final result and registered with Res.
- Width rules: each slice adder is SLICE+1 bits wide; the MSB is the inter-slice carry. There is no truncation except at the final Carry.

Optional Feature:
- Macro: ADDSUB_SEQ_BCD_EN.
- Defined, Dec=1 (captured), per 4-bit nibble within each slice:
  - Add: if nibble sum > 9, add 6 mod 16 and set nibble carry=1.
  - Sub: Sub and Carry_In keep the binary convention. B_i is the 9's complement per nibble (9-B, not ~B). If the nibble sum > 9, add 6 mod 16 and set nibble carry=1. A carry of 1 means no borrow.
  - Overflow is forced to 0 in decimal mode. Half_Carry is the decimal nibble-0 carry.
- Not defined: the Dec port exists but is ignored; pure binary operation. Latency is identical in both builds.

Decomposition:
- Shared package addsub_pkg:
  - state enum {IDLE, RUN}.
  - Function slice_add(a, b, cin, dec) returning {cout, sum, nib0_cout}.
  - Constants BCD_ADJ=4'h6 and BCD_MAX=4'h9.
- One sub-module, addsub_slice: combinational SLICE-bit adder with nibble chain and optional BCD correction, used once per cycle by the FSM.

Test Plan (WIDTH=16, SLICE=4):
- Start A=16'h1234 B=16'h0FFF Sub=0 Cin=0 → Done 4 cycles after Start edge (cycle after edge k+4); Res=16'h2233, Carry=0, Half_Carry=1, Zero=0, Overflow=0; Busy high exactly 4 cycles.
- A=16'h0000 B=16'h0001 Sub=1 Cin=1 → Res=16'hFFFF, Carry=0 (borrow), Zero=0, Overflow=0. Then A=16'hFFFF B=16'h0001 Sub=0 Cin=0 → Res=16'h0000, Carry=1, Zero=1, Half_Carry=1.
- A=16'h7FFF B=16'h0001 add → Res=16'h8000, Overflow=1; A=16'h8000 B=16'h0001 Sub=1 Cin=1 → Res=16'h7FFF, Overflow=1, Carry=1.
- Start pulsed again 2 cycles into RUN with different operands → ignored; first result unchanged. Start asserted during the Done cycle → accepted; second Done exactly 4 cycles later.
- RESET_n low 2 cycles into RUN → Busy, Done and all outputs 0 immediately (asynchronous); after release, no Done appears without a new Start.
- (ADDSUB_SEQ_BCD_EN) Dec=1: A=16'h0999 B=16'h0001 Cin=0 → Res=16'h1000, Carry=0. A=16'h0100 B=16'h0001 Sub=1 Cin=1 → Res=16'h0099, Carry=1. Without the macro, the same first stimulus → Res=16'h099A.
